// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: byte stream -> little-endian words, core held in reset until done.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t                state, state_nx;
  logic [7:0]            n_lo;
  logic [15:0]           n_words;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           asm_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            chk_q;
`endif

  logic        xfer, word_fire, last_word, too_big;
  logic [15:0] n_rx;

  always_comb begin
    rx_ready = 1'b0;
    if (!reset) begin
      case (state)
        DONE, ERR: rx_ready = 1'b0;
        default:   rx_ready = 1'b1;
      endcase
    end
  end

  assign xfer      = rx_valid && rx_ready;
  assign n_rx      = {rx_data, n_lo};
  assign too_big   = 32'(n_rx) > (32'd1 << ADDR_WIDTH);
  assign word_fire = (state == DATA) && xfer && (byte_idx == 2'd3);
  // word_idx has one spare bit so a full 2**ADDR_WIDTH image still compares correctly
  assign last_word = (32'(word_idx) + 32'd1) == 32'(n_words);

  always_comb begin
    state_nx = state;
    case (state)
      CNT_LO: if (xfer) state_nx = CNT_HI;
      CNT_HI: begin
        if (xfer) begin
          if (too_big)           state_nx = ERR;
          else if (n_rx == 16'd0) state_nx = AFTER_DATA;
          else                   state_nx = DATA;
        end
      end
      DATA: if (word_fire && last_word) state_nx = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      CHK: if (xfer) state_nx = (rx_data == chk_q) ? DONE : ERR;
`endif
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CNT_LO;
      n_lo       <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state   <= state_nx;
      imem_we <= word_fire;
      done    <= (state_nx == DONE);
      error   <= (state_nx == ERR);
      // lags done by one edge so the final write lands first
      core_reset <= ~done;
      if (state == CNT_LO && xfer) n_lo <= rx_data;
      if (state == CNT_HI && xfer) begin
        n_words  <= n_rx;
        word_idx <= '0;
        byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
        chk_q    <= '0;
`endif
      end
      if (state == DATA && xfer) begin
        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        chk_q    <= chk_q ^ rx_data;
`endif
        case (byte_idx)
          2'd0: asm_q[7:0]   <= rx_data;
          2'd1: asm_q[15:8]  <= rx_data;
          2'd2: asm_q[23:16] <= rx_data;
          default: begin
            imem_addr  <= word_idx[ADDR_WIDTH-1:0];
            imem_wdata <= {rx_data, asm_q};
            word_idx   <= word_idx + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-level model predicts writes and final status.
module tb_imem_loader;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic       clk = 0, reset = 1;
  logic [7:0] rx_data = 0;
  logic       rx_valid = 0;
  logic       rx_ready, imem_we, core_reset, done, error;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t exp_w[$];
  int  checks = 0, failures = 0;
  int  exp_accept;
  bit  exp_done, exp_err, exp_final_wr;
  int  cyc = 0, wr_count = 0;
  int  wcyc[$];
  logic [7:0]  last_addr;
  logic [31:0] last_data;
  bit  prev_done = 0, cr_pend = 0, prev_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] b[$]);
    logic [7:0] x = 0;
    for (int i = 2; i < b.size(); i++) x ^= b[i];
    return x;
  endfunction

  // Stream-level model: writes for every complete word delivered, final status from totals.
  task automatic model(input logic [7:0] b[$]);
    int n, total;
    logic [7:0] x;
    wr_t w;
    exp_w.delete();
    exp_done = 0; exp_err = 0; exp_final_wr = 0;
    exp_accept = b.size();
    if (b.size() < 2) return;
    n = {b[1], b[0]};
    if (n > 256) begin exp_err = 1; exp_accept = 2; return; end
    x = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++)
        if (2 + 4*i + k < b.size()) x ^= b[2 + 4*i + k];
      if (2 + 4*i + 3 < b.size()) begin
        w.a = 8'(i);
        w.d = {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]};
        exp_w.push_back(w);
      end
    end
    total = 2 + 4*n + CHK_EN;
    if (exp_accept > total) exp_accept = total;
    if (b.size() >= total) begin
      if (CHK_EN != 0) begin
        exp_done = (b[2+4*n] == x);
        exp_err  = !exp_done;
      end else exp_done = 1;
      exp_final_wr = (n > 0) && (CHK_EN == 0);
    end
  endtask

  // Per-cycle compare against the model's write queue and status timing.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!reset) begin
      if (imem_we) begin
        wr_count++;
        wcyc.push_back(cyc);
        last_addr = imem_addr;
        last_data = imem_wdata;
        if (exp_w.size() == 0) chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
        else begin
          chk("wr_addr", 32'(imem_addr), 32'(exp_w[0].a));
          chk("wr_data", imem_wdata, exp_w[0].d);
          void'(exp_w.pop_front());
        end
      end
      if (cr_pend) begin
        chk("core_reset_fall", 32'(core_reset), 0);
        cr_pend = 0;
      end
      if (done && !prev_done) begin
        chk("done_expected", 32'(exp_done), 1);
        chk("core_reset_at_done", 32'(core_reset), 1);
        if (exp_final_wr) begin
          chk("done_with_write", 32'(imem_we), 1);
          chk("done_last_write", 32'(exp_w.size()), 0);
        end
        cr_pend = 1;
      end
      if (error && !prev_err) begin
        chk("err_done_low", 32'(done), 0);
        chk("err_core_reset", 32'(core_reset), 1);
      end
      prev_done = done;
      prev_err  = error;
    end else begin
      prev_done = 0; prev_err = 0; cr_pend = 0;
    end
  end

  task automatic do_reset(input bit check_vals);
    @(negedge clk);
    reset = 1; rx_valid = 0;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    if (check_vals) begin
      chk("rst_we", 32'(imem_we), 0);
      chk("rst_addr", 32'(imem_addr), 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_core_reset", 32'(core_reset), 1);
    end
    reset = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(rx_ready), 1);
    wr_count = 0;
    wcyc.delete();
  endtask

  // Called at a negedge; each byte offered one cycle, refusal expected past the image.
  task automatic send(input logic [7:0] b[$], input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      rx_valid = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      rx_valid = 1;
      rx_data  = b[i];
      if (i < exp_accept) chk("ready", 32'(rx_ready), 1);
      else                chk("refuse", 32'(rx_ready), 0);
      @(negedge clk);
    end
    rx_valid = 0;
  endtask

  task automatic finish_check(input string name);
    repeat (3) @(negedge clk);
    chk({name, "_pending"}, 32'(exp_w.size()), 0);
    chk({name, "_done"}, 32'(done), 32'(exp_done));
    chk({name, "_error"}, 32'(error), 32'(exp_err));
    chk({name, "_core_reset"}, 32'(core_reset), 32'(!exp_done));
  endtask

  task automatic run(input string name, input logic [7:0] b[$], input bit gaps);
    model(b);
    send(b, gaps);
    finish_check(name);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] t[$];

    do_reset(1);

    // N=2 full rate
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h05, 8'h15, 8'h00};
    if (CHK_EN != 0) s.push_back(xsum(s));
    model(s);
    chk("pin_w0_addr", 32'(exp_w[0].a), 0);
    chk("pin_w0_data", exp_w[0].d, 32'h0000_0513);
    chk("pin_w1_data", exp_w[1].d, 32'h0015_05B3);
    send(s, 0);
    finish_check("full");
    chk("full_writes", 32'(wr_count), 2);
    if (wcyc.size() == 2) chk("full_spacing", 32'(wcyc[1] - wcyc[0]), 4);
    else chk("full_spacing_cnt", 32'(wcyc.size()), 2);
    chk("full_last_data", last_data, 32'h0015_05B3);
    chk("full_last_addr", 32'(last_addr), 1);

    // same image with random idle gaps
    do_reset(1);
    run("gaps", s, 1);
    chk("gaps_writes", 32'(wr_count), 2);

    // N=0
    do_reset(0);
    if (CHK_EN != 0) begin
      run("n0_good", '{8'h00, 8'h00, 8'h00}, 0);
      do_reset(0);
      run("n0_bad", '{8'h00, 8'h00, 8'h01}, 0);
    end else begin
      run("n0", '{8'h00, 8'h00, 8'hAA}, 0);
    end
    chk("n0_writes", 32'(wr_count), 0);

    // N=0x0101 too large, extra byte must be refused
    do_reset(0);
    run("big", '{8'h01, 8'h01, 8'h13}, 0);
    chk("big_writes", 32'(wr_count), 0);
    chk("big_ready", 32'(rx_ready), 0);

    // N=0x0100 maximal image
    do_reset(0);
    s = '{8'h00, 8'h01};
    for (int w = 0; w < 256; w++) begin
      s.push_back(8'(w)); s.push_back(8'(~w)); s.push_back(8'h5A); s.push_back(8'hC3);
    end
    if (CHK_EN != 0) s.push_back(xsum(s));
    run("max", s, 0);
    chk("max_writes", 32'(wr_count), 256);
    chk("max_last_addr", 32'(last_addr), 32'hFF);
    chk("max_last_data", last_data, 32'hC35A_00FF);

    if (CHK_EN != 0) begin
      do_reset(0);
      run("cs_good", '{8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h16}, 0);
      chk("cs_good_writes", 32'(wr_count), 1);
      do_reset(0);
      run("cs_bad", '{8'h01, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h17}, 0);
      chk("cs_bad_writes", 32'(wr_count), 1);
    end

    // reset after 6 data bytes of a 2-word load, then a 1-word reload
    do_reset(0);
    t = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h05};
    run("partial", t, 0);
    chk("partial_writes", 32'(wr_count), 1);
    do_reset(0);
    t = '{8'h01, 8'h00, 8'h37, 8'h01, 8'h00, 8'h00};
    if (CHK_EN != 0) t.push_back(xsum(t));
    run("reload", t, 0);
    chk("reload_writes", 32'(wr_count), 1);
    chk("reload_addr", 32'(last_addr), 0);
    chk("reload_data", last_data, 32'h0000_0137);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program writer for the 5-stage RISC-V core's instruction memory. Accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit words, and writes them to consecutive instruction-memory word addresses. It holds the core in reset until the image is complete. The core's fetch stage is the reader of this memory; this block is its writer.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; maximum image is 2**ADDR_WIDTH words.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready at a rising edge.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  word being written.
- core_reset  output  1  reset to the core; high until the load succeeds.
- done  output  1  level; image loaded successfully.
- error  output  1  level; load aborted.

## Operation
- Stream format:
  - COUNT_LO byte, then COUNT_HI byte. These form a 16-bit word count N.
  - N×4 data bytes, least-significant byte first within each word.
  - Checksum byte only when LOADER_CHECKSUM_EN is defined.
- FSM states: CNT_LO, CNT_HI, DATA, CHK, DONE, ERR. Reset state is CNT_LO.
- CNT_LO → CNT_HI on transfer; the byte is latched as N[7:0].
- CNT_HI on transfer:
  - N > 2**ADDR_WIDTH → ERR.
  - N == 0 → CHK if checksum is enabled, else DONE.
  - Otherwise → DATA; the word index and byte index are cleared.
- DATA:
  - Byte k of the current word goes into bits [8k+7:8k] of the assembly register.
  - On the 4th byte, a write is issued: imem_we=1, imem_addr=word index, imem_wdata=assembled word. The word index then increments.
  - After word N−1: → CHK if checksum is enabled, else DONE.
- CHK: on transfer, byte == running checksum → DONE; otherwise → ERR.
- DONE and ERR are terminal. Only reset leaves them.
- rx_ready = 1 in CNT_LO, CNT_HI, DATA and CHK, and 0 in DONE, ERR and while reset is high.
- Bytes are never dropped or duplicated. Idle cycles (rx_valid=0) may occur anywhere, including between bytes of one word, with no effect on state.
- Reset mid-load: all state and the partial word are discarded and the loader restarts at CNT_LO. Words already written stay in memory; they are overwritten by the next load.

## Timing
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - done=0, error=0, core_reset=1.
  - rx_ready=0 while reset is high, then 1 in the first cycle after reset is released.
- All outputs except rx_ready are registered. rx_ready is decoded from the state.
- Write latency: the 4th byte transfers at edge E. From edge E, imem_we/addr/wdata are valid for exactly one cycle, and imem_we returns to 0 at edge E+1 unless another word completes.
- The loader never stalls: rx_ready stays 1 during write cycles. Full rate is one byte per cycle, which gives one write every 4 cycles.
- Entering DONE:
  - done rises at the same edge as the final write strobe (or the checksum transfer).
  - core_reset falls exactly one edge later, so the final write lands before the core leaves reset.
- Entering ERR: error rises at the transition edge. core_reset stays 1 and done stays 0.
- imem_addr width rule: the word index is ADDR_WIDTH+1 bits internally. N == 2**ADDR_WIDTH is legal; the last write goes to address 2**ADDR_WIDTH−1.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers all data bytes; count bytes are excluded.
  - It is cleared on reset and on CNT_HI.
  - The CHK state and its trailing byte are required. A mismatch → ERR.
- Undefined:
  - The CHK state and XOR register are absent.
  - DONE follows the last data word, or CNT_HI when N == 0.
  - A byte sent after the image is refused (rx_ready=0).

## Test plan
- N=2, bytes 13 05 00 00 then B3 05 15 00 at full rate:
  - imem_we at addr 0 with 0x00000513, then 4 cycles later at addr 1 with 0x001505B3.
  - done rises with the second write; core_reset falls one cycle later.
- Same image with random rx_valid gaps (including mid-word): identical writes, addresses and final state as at full rate.
- N=0: with the checksum disabled, DONE follows CNT_HI and no imem_we ever occurs. With LOADER_CHECKSUM_EN, checksum 0x00 → DONE and 0x01 → ERR.
- ADDR_WIDTH=8, N=0x0101: error=1 right after CNT_HI, rx_ready=0, core_reset stays 1, no writes. N=0x0100 completes with the last write at addr 0xFF.
- LOADER_CHECKSUM_EN, N=1, data 13 05 00 00 (XOR 0x16):
  - Checksum 0x16 → done.
  - Checksum 0x17 → error, with the word still written once.
- Reset asserted after 6 data bytes of a 2-word load, then a full 1-word reload: one write at addr 0 from the first load, one at addr 0 from the reload. The partial word is never written; done is only set by the reload.
